// File: rtl/anita4_trig_pkg.sv
// Shared encodings and default widths for the ANITA-4 phi-sector trigger.
package anita4_trig_pkg;

  localparam int DEF_NUM_PHI   = 16;
  localparam int DEF_NUM_POL   = 2;
  localparam int DEF_STRETCH_W = 4;
  localparam int DEF_HOLDOFF_W = 8;
  localparam int DEF_COUNT_W   = 16;

  typedef enum logic [1:0] {
    MODE_2OF2   = 2'd0,
    MODE_2OF3   = 2'd1,
    MODE_SINGLE = 2'd2,
    MODE_3OF3   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } state_e;

endpackage

// File: rtl/anita4_phi_coinc_trigger_if.sv
// Control/status bundle between the trigger core and its driver.
interface anita4_phi_coinc_trigger_if
  import anita4_trig_pkg::*;
#(
  parameter int NUM_PHI   = DEF_NUM_PHI,
  parameter int NUM_POL   = DEF_NUM_POL,
  parameter int STRETCH_W = DEF_STRETCH_W,
  parameter int HOLDOFF_W = DEF_HOLDOFF_W,
  parameter int COUNT_W   = DEF_COUNT_W
);
  localparam int NB = NUM_POL * NUM_PHI;

  logic [NB-1:0]        phi_i;
  logic [NB-1:0]        phi_mask_i;
  logic [1:0]           mode_i;
  logic [STRETCH_W-1:0] stretch_i;
  logic [HOLDOFF_W-1:0] holdoff_i;
  logic                 disable_i;
  logic                 clear_i;
  logic                 trig_o;
  logic [NUM_POL-1:0]   pol_o;
  logic [NB-1:0]        phi_o;
  logic [COUNT_W-1:0]   raw_count_o;
  logic [COUNT_W-1:0]   acc_count_o;
  logic [COUNT_W-1:0]   dead_count_o;

  modport master (
    output phi_i, phi_mask_i, mode_i, stretch_i, holdoff_i, disable_i, clear_i,
    input  trig_o, pol_o, phi_o, raw_count_o, acc_count_o, dead_count_o
  );

  modport slave (
    input  phi_i, phi_mask_i, mode_i, stretch_i, holdoff_i, disable_i, clear_i,
    output trig_o, pol_o, phi_o, raw_count_o, acc_count_o, dead_count_o
  );

endinterface

// File: rtl/anita4_phi_stretch.sv
// Single-bit hit stretcher: output stays high i_stretch+1 cycles past the last hit.
module anita4_phi_stretch #(
  parameter int STRETCH_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_hit,
  input  logic [STRETCH_W-1:0] i_stretch,
  output logic                 o_s
);
  logic [STRETCH_W-1:0] r_cnt;
  logic                 r_s;

  // A new hit reloads the hold counter; otherwise count down while holding high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_s   <= 1'b0;
    end else if (i_hit) begin
      r_cnt <= i_stretch;
      r_s   <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      r_s   <= 1'b1;
    end else begin
      r_s   <= 1'b0;
    end
  end

  assign o_s = r_s;

endmodule

// File: rtl/anita4_phi_coinc_trigger.sv
// Phi-sector M-of-N adjacency trigger: stretch -> coincidence -> any -> holdoff FSM,
// plus saturating raw/accepted/deadtime counters.
module anita4_phi_coinc_trigger
  import anita4_trig_pkg::*;
#(
  parameter int NUM_PHI   = DEF_NUM_PHI,
  parameter int NUM_POL   = DEF_NUM_POL,
  parameter int STRETCH_W = DEF_STRETCH_W,
  parameter int HOLDOFF_W = DEF_HOLDOFF_W,
  parameter int COUNT_W   = DEF_COUNT_W
) (
  input  logic                       clk250_i,
  input  logic                       rst_i,
  anita4_phi_coinc_trigger_if.slave  bus
);
  localparam int NB = NUM_POL * NUM_PHI;

  logic [NB-1:0]        w_s, w_coinc;
  logic [NUM_POL-1:0]   w_pol_any;
  logic                 w_a, w_b, w_c;
  logic [NB-1:0]        r_coinc, r_s_d1, r_s_d2;
  logic                 r_any, r_any_d, r_dis;
  logic [NUM_POL-1:0]   r_pol_any;
  state_e               r_state, w_state_nxt;
  logic [HOLDOFF_W-1:0] r_hcnt, w_hcnt_nxt;
  logic                 w_fire;
  logic                 r_trig;
  logic [NUM_POL-1:0]   r_pol;
  logic [NB-1:0]        r_phi;
  logic [COUNT_W-1:0]   r_raw, r_acc, r_dead;

  for (genvar g = 0; g < NB; g++) begin : g_str
    anita4_phi_stretch #(.STRETCH_W(STRETCH_W)) u_str (
      .i_clk     (clk250_i),
      .i_rst     (rst_i),
      .i_hit     (bus.phi_i[g]),
      .i_stretch (bus.stretch_i),
      .o_s       (w_s[g])
    );
  end

  // Per-sector adjacency test; neighbours wrap around within each polarisation.
  always_comb begin
    w_coinc = '0;
    w_a     = 1'b0;
    w_b     = 1'b0;
    w_c     = 1'b0;
    for (int p = 0; p < NUM_POL; p++) begin
      for (int i = 0; i < NUM_PHI; i++) begin
        w_a = w_s[p*NUM_PHI + i];
        w_b = w_s[p*NUM_PHI + ((i + 1) % NUM_PHI)];
        w_c = w_s[p*NUM_PHI + ((i + 2) % NUM_PHI)];
        case (bus.mode_i)
          MODE_2OF2:   w_coinc[p*NUM_PHI + i] = w_a & w_b;
          MODE_2OF3:   w_coinc[p*NUM_PHI + i] = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
          MODE_SINGLE: w_coinc[p*NUM_PHI + i] = w_a;
          MODE_3OF3:   w_coinc[p*NUM_PHI + i] = w_a & w_b & w_c;
          default:     w_coinc[p*NUM_PHI + i] = 1'b0;
        endcase
        w_coinc[p*NUM_PHI + i] = w_coinc[p*NUM_PHI + i] & ~bus.phi_mask_i[p*NUM_PHI + i];
      end
    end
  end

  // Per-polarisation OR of the registered coincidences.
  always_comb begin
    w_pol_any = '0;
    for (int p = 0; p < NUM_POL; p++) w_pol_any[p] = |r_coinc[p*NUM_PHI +: NUM_PHI];
  end

  // Coincidence and OR stages; the stretched pattern rides two delays to stay aligned with any_q.
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      r_coinc   <= '0;
      r_s_d1    <= '0;
      r_s_d2    <= '0;
      r_any     <= 1'b0;
      r_any_d   <= 1'b0;
      r_pol_any <= '0;
      r_dis     <= 1'b0;
    end else begin
      r_coinc   <= w_coinc;
      r_s_d1    <= w_s;
      r_s_d2    <= r_s_d1;
      r_any     <= |r_coinc;
      r_any_d   <= r_any;
      r_pol_any <= w_pol_any;
      r_dis     <= bus.disable_i;
    end
  end

  // Trigger FSM next-state: fire from IDLE, count holdoff down to zero before rearming.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_any && !r_dis) begin
          w_fire      = 1'b1;
          w_hcnt_nxt  = bus.holdoff_i;
          w_state_nxt = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (r_hcnt == '0) w_state_nxt = ST_IDLE;
        else              w_hcnt_nxt  = r_hcnt - 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, trigger pulse and latched pattern; phi/pol hold until the next trigger.
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_trig  <= 1'b0;
      r_phi   <= '0;
      r_pol   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_trig  <= w_fire;
      if (w_fire) begin
        r_phi <= r_s_d2;
        r_pol <= r_pol_any;
      end
    end
  end

  // Saturating housekeeping counters; clear wins over any increment on the same edge.
  always_ff @(posedge clk250_i) begin
    if (rst_i || bus.clear_i) begin
      r_raw  <= '0;
      r_acc  <= '0;
      r_dead <= '0;
    end else begin
      if (r_any && !r_any_d && r_raw != '1) r_raw <= r_raw + 1'b1;
      if (w_fire && r_acc != '1)            r_acc <= r_acc + 1'b1;
      if ((r_state == ST_HOLDOFF || r_dis) && r_dead != '1) r_dead <= r_dead + 1'b1;
    end
  end

  assign bus.trig_o       = r_trig;
  assign bus.pol_o        = r_pol;
  assign bus.phi_o        = r_phi;
  assign bus.raw_count_o  = r_raw;
  assign bus.acc_count_o  = r_acc;
  assign bus.dead_count_o = r_dead;

endmodule
